// File: rtl/udp2fifoc_pkg.sv
// udp2fifoc_pkg: shared ethernet command constants and state encodings
package udp2fifoc_pkg;
    localparam int ETH_MIN_LEN = 12;
    localparam int ETH_MAX_LEN = 32;
    localparam logic [15:0] ETH_CMD_HDR = 16'h55AA;
    typedef enum logic [7:0] {
        IDLE = 8'h00,
        RECV = 8'h01,
        DROP = 8'h02,
        CLR  = 8'h03,
        CHKL = 8'h04,
        SEND = 8'h05,
        DONE = 8'h06
    } state_t;
endpackage

// File: rtl/udp2fifoc.sv
// udp2fifoc: moves UDP payload bytes into the command FIFO and hands length-checked frames to the parser
module udp2fifoc
    import udp2fifoc_pkg::*;
#(
    parameter int MIN_LEN = ETH_MIN_LEN,
    parameter int MAX_LEN = ETH_MAX_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        udp_rxdv,
    input  logic [7:0]  udp_rxd,
    input  logic        udp_rxlast,
    output logic        fifoc_txen,
    output logic [7:0]  fifoc_txd,
    input  logic        fifoc_full,
    output logic        fifoc_clr,
    output logic        fs,
    input  logic        fd,
    output logic [11:0] data_len,
    output logic [7:0]  drop_cnt
);
    localparam logic [11:0] MIN_L = 12'(MIN_LEN);
    localparam logic [11:0] MAX_L = 12'(MAX_LEN);

    state_t      state, state_nx;
    logic [11:0] cnt, cnt_nx;
    logic        in_pkt, wr, drop_inc;
    logic        byte_last;

    assign byte_last  = udp_rxdv && udp_rxlast;
    assign fifoc_txen = wr && !rst;
    assign fifoc_txd  = fifoc_txen ? udp_rxd : 8'h00;
    assign fifoc_clr  = state == CLR;

    // next state, zero-latency FIFO write and drop accounting
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wr       = 1'b0;
        drop_inc = 1'b0;
        case (state)
            IDLE: if (udp_rxdv && !in_pkt) begin
                wr       = 1'b1;
                cnt_nx   = 12'd1;
                state_nx = udp_rxlast ? CHKL : RECV;
            end
            RECV: if (udp_rxdv) begin
                if (cnt < MAX_L && !fifoc_full) begin
                    wr       = 1'b1;
                    cnt_nx   = cnt + 12'd1;
                    state_nx = udp_rxlast ? CHKL : RECV;
                end else begin
                    state_nx = udp_rxlast ? CLR : DROP;
                end
            end
            DROP: state_nx = byte_last ? CLR : DROP;
            CLR: begin
                drop_inc = 1'b1;
                state_nx = IDLE;
            end
            CHKL: state_nx = cnt < MIN_L ? CLR : SEND;
            SEND: begin
                drop_inc = byte_last;
                state_nx = fd ? DONE : SEND;
            end
            DONE: begin
                drop_inc = byte_last;
                state_nx = fd ? DONE : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // state, counters, frame length latch and registered frame-start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            data_len <= '0;
            drop_cnt <= '0;
            fs       <= 1'b0;
            in_pkt   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            fs    <= state_nx == SEND;
            if (state == CHKL && cnt >= MIN_L)
                data_len <= cnt;
            if (drop_inc)
                drop_cnt <= drop_cnt + 8'd1;
            if (udp_rxdv)
                in_pkt <= !udp_rxlast;
        end
    end
endmodule

// File: tb/tb_udp2fifoc.sv
// tb_udp2fifoc: directed packets with a write scoreboard for udp2fifoc
module tb_udp2fifoc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        udp_rxdv = 1'b0;
    logic [7:0]  udp_rxd = 8'h00;
    logic        udp_rxlast = 1'b0;
    logic        fifoc_txen;
    logic [7:0]  fifoc_txd;
    logic        fifoc_full = 1'b0;
    logic        fifoc_clr;
    logic        fs;
    logic        fd = 1'b0;
    logic [11:0] data_len;
    logic [7:0]  drop_cnt;

    logic [7:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int clr_n = 0;
    int fs_n = 0;
    int clr0, fs0;

    udp2fifoc dut (
        .clk(clk), .rst(rst), .udp_rxdv(udp_rxdv), .udp_rxd(udp_rxd),
        .udp_rxlast(udp_rxlast), .fifoc_txen(fifoc_txen), .fifoc_txd(fifoc_txd),
        .fifoc_full(fifoc_full), .fifoc_clr(fifoc_clr), .fs(fs), .fd(fd),
        .data_len(data_len), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // monitor: pops expected write data whenever the DUT writes the FIFO
    initial forever begin
        @(negedge clk);
        if (fifoc_clr) clr_n++;
        if (fs) fs_n++;
        if (fifoc_txen) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got txd=%02h, required no write", fifoc_txd);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (fifoc_txd !== e) begin
                    n_err++;
                    $display("FAIL write_data: got %02h required %02h", fifoc_txd, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    task automatic wait_fs(input logic v, input string nm);
        int k = 0;
        @(negedge clk);
        while (fs !== v && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk(nm, int'(fs), int'(v));
    endtask

    // drives an n-byte packet; expected writes are pushed as each byte is issued
    task automatic send_pkt(input int n, input int nwr, input int full_at,
                            input int rst_lo, input int rst_hi, input logic [7:0] seed,
                            input logic fd_after);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            d = i == 0 ? 8'h55 : i == 1 ? 8'hAA : seed + 8'(i);
            @(posedge clk);
            #1;
            if (i < nwr || (rst_hi >= 0 && i > rst_hi)) exp_q.push_back(d);
            rst = (i >= rst_lo && i <= rst_hi);
            fifoc_full = (full_at >= 0 && i >= full_at);
            udp_rxdv = 1'b1;
            udp_rxd = d;
            udp_rxlast = (i == n - 1);
        end
        @(posedge clk);
        #1;
        udp_rxdv = 1'b0;
        udp_rxlast = 1'b0;
        fifoc_full = 1'b0;
        rst = 1'b0;
        if (fd_after) fd = 1'b1;
    endtask

    task automatic handshake();
        fd = 1'b1;
        wait_fs(1'b0, "fs_drop_on_fd");
        @(posedge clk);
        #1;
        fd = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_fs", int'(fs), 0);
        chk("rst_txen", int'(fifoc_txen), 0);
        chk("rst_txd", int'(fifoc_txd), 0);
        chk("rst_clr", int'(fifoc_clr), 0);
        chk("rst_data_len", int'(data_len), 0);
        chk("rst_drop_cnt", int'(drop_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // valid 12-byte frame
        clr0 = clr_n;
        send_pkt(12, 12, -1, -1, -1, 8'h10, 1'b0);
        wait_fs(1'b1, "valid_fs");
        chk("valid_data_len", int'(data_len), 12);
        chk("valid_drop_cnt", int'(drop_cnt), 0);
        chk("valid_writes_done", exp_q.size(), 0);
        handshake();
        chk("valid_no_clr", clr_n - clr0, 0);

        // long 40-byte packet
        clr0 = clr_n; fs0 = fs_n;
        send_pkt(40, 32, -1, -1, -1, 8'h20, 1'b0);
        repeat (4) @(negedge clk);
        chk("long_writes_done", exp_q.size(), 0);
        chk("long_clr_pulses", clr_n - clr0, 1);
        chk("long_drop_cnt", int'(drop_cnt), 1);
        chk("long_no_fs", fs_n - fs0, 0);

        // short 8-byte packet
        clr0 = clr_n; fs0 = fs_n;
        send_pkt(8, 8, -1, -1, -1, 8'h30, 1'b0);
        repeat (4) @(negedge clk);
        chk("short_writes_done", exp_q.size(), 0);
        chk("short_clr_pulses", clr_n - clr0, 1);
        chk("short_drop_cnt", int'(drop_cnt), 2);
        chk("short_no_fs", fs_n - fs0, 0);

        // second packet while the parser is busy
        send_pkt(12, 12, -1, -1, -1, 8'h40, 1'b0);
        wait_fs(1'b1, "busy_first_fs");
        clr0 = clr_n;
        send_pkt(12, 0, -1, -1, -1, 8'h50, 1'b0);
        repeat (2) @(negedge clk);
        chk("busy_fs_held", int'(fs), 1);
        chk("busy_data_len", int'(data_len), 12);
        chk("busy_drop_cnt", int'(drop_cnt), 3);
        chk("busy_no_clr", clr_n - clr0, 0);
        handshake();

        // FIFO fills at byte 5
        clr0 = clr_n;
        send_pkt(12, 4, 4, -1, -1, 8'h60, 1'b0);
        repeat (4) @(negedge clk);
        chk("full_writes_done", exp_q.size(), 0);
        chk("full_clr_pulses", clr_n - clr0, 1);
        chk("full_drop_cnt", int'(drop_cnt), 4);

        // reset across bytes 6..10; bytes 11,12 arrive as a fresh short packet
        clr0 = clr_n;
        send_pkt(12, 5, -1, 5, 9, 8'h70, 1'b0);
        repeat (4) @(negedge clk);
        chk("rstmid_writes_done", exp_q.size(), 0);
        chk("rstmid_clr_pulses", clr_n - clr0, 1);
        chk("rstmid_drop_cnt", int'(drop_cnt), 1);
        chk("rstmid_data_len", int'(data_len), 0);

        // next packet accepted; fd already high on entry to SEND
        fs0 = fs_n;
        send_pkt(12, 12, -1, -1, -1, 8'h80, 1'b1);
        repeat (6) @(negedge clk);
        chk("after_rst_writes_done", exp_q.size(), 0);
        chk("after_rst_data_len", int'(data_len), 12);
        chk("fd_early_fs_cycles", fs_n - fs0, 1);
        @(posedge clk);
        #1;
        fd = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_fs_low", int'(fs), 0);
        chk("final_drop_cnt", int'(drop_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
